// File: rtl/mul_pipe.sv
// Pipelined RV32M/RV64M multiplier: MUL/MULH/MULHSU/MULHU with a configurable
// accept-to-result latency, global-stall freeze, output backpressure and flush.
module mul_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [1:0]                     in_op,
  input  logic [XLEN-1:0]                in_rs1,
  input  logic [XLEN-1:0]                in_rs2,
  input  logic [4:0]                     in_rd_addr,
  input  logic [XLEN-1:0]                in_tag,
  input  logic [31:0]                    in_instr,
  input  logic                           freeze,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [XLEN-1:0]                out_data,
  output logic [4:0]                     out_rd_addr,
  output logic [XLEN-1:0]                out_tag,
  output logic [31:0]                    out_instr,
  output logic                           busy,
  output logic [$clog2(STAGES+1)-1:0]    inflight
);

  localparam int CW = $clog2(STAGES+1);

  logic [STAGES:1]     valid_q, valid_d;
  logic [STAGES:1]     low_q, low_d;
  logic [4:0]          rd_q    [1:STAGES];
  logic [4:0]          rd_d    [1:STAGES];
  logic [XLEN-1:0]     tag_q   [1:STAGES];
  logic [XLEN-1:0]     tag_d   [1:STAGES];
  logic [31:0]         instr_q [1:STAGES];
  logic [31:0]         instr_d [1:STAGES];
  logic [XLEN:0]       a_q, a_d, b_q, b_d;
  logic [2*XLEN-1:0]   prod_q  [2:STAGES];
  logic [2*XLEN-1:0]   prod_d  [2:STAGES];

  logic                advance;
  logic                rs1_signed, rs2_signed;
  logic [2*XLEN-1:0]   a_ext, b_ext, prod_full;

  // The (XLEN+1)-bit operands are sign-extended to 2*XLEN; the product modulo
  // 2^(2*XLEN) is exactly the part of the signed product that is kept.
  assign a_ext     = {{(XLEN-1){a_q[XLEN]}}, a_q};
  assign b_ext     = {{(XLEN-1){b_q[XLEN]}}, b_q};
  assign prod_full = a_ext * b_ext;

  always_comb begin
    advance    = ~freeze & (~valid_q[STAGES] | out_ready);
    rs1_signed = (in_op == 2'b01) | (in_op == 2'b10);
    rs2_signed = (in_op == 2'b01);

    valid_d = valid_q;
    low_d   = low_q;
    rd_d    = rd_q;
    tag_d   = tag_q;
    instr_d = instr_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;

    if (flush) begin
      valid_d = '0;
    end else if (advance) begin
      valid_d = {valid_q[STAGES-1:1], in_valid};
    end

    // Payloads only move on advance so an idle or stalled pipe stays quiet.
    if (advance) begin
      rd_d[1]    = in_rd_addr;
      tag_d[1]   = in_tag;
      instr_d[1] = in_instr;
      low_d[1]   = (in_op == 2'b00);
      a_d        = {rs1_signed & in_rs1[XLEN-1], in_rs1};
      b_d        = {rs2_signed & in_rs2[XLEN-1], in_rs2};
      for (int s = 2; s <= STAGES; s++) begin
        rd_d[s]    = rd_q[s-1];
        tag_d[s]   = tag_q[s-1];
        instr_d[s] = instr_q[s-1];
        low_d[s]   = low_q[s-1];
      end
      prod_d[2] = prod_full;
      for (int s = 3; s <= STAGES; s++) begin
        prod_d[s] = prod_q[s-1];
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int s = 1; s <= STAGES; s++) begin
      inflight = inflight + {{(CW-1){1'b0}}, valid_q[s]};
    end
    busy = |valid_q[STAGES-1:1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      low_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      for (int s = 1; s <= STAGES; s++) begin
        rd_q[s]    <= '0;
        tag_q[s]   <= '0;
        instr_q[s] <= '0;
      end
      for (int s = 2; s <= STAGES; s++) begin
        prod_q[s] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      low_q   <= low_d;
      rd_q    <= rd_d;
      tag_q   <= tag_d;
      instr_q <= instr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
    end
  end

  assign in_ready    = advance;
  assign out_valid   = valid_q[STAGES];
  assign out_data    = low_q[STAGES] ? prod_q[STAGES][XLEN-1:0]
                                     : prod_q[STAGES][2*XLEN-1:XLEN];
  assign out_rd_addr = rd_q[STAGES];
  assign out_tag     = tag_q[STAGES];
  assign out_instr   = instr_q[STAGES];

endmodule

// File: tb/tb_mul_pipe.sv
// Bench for mul_pipe: three instances (STAGES 2, 3, 6) share one stimulus
// stream and are checked every cycle against a slot-array model of the pipe.
module tb_mul_pipe;

  localparam int N = 3;

  function automatic int st_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 3 : 6);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, freeze, flush, out_ready;
  logic [1:0]  in_op;
  logic [31:0] in_rs1, in_rs2, in_tag, in_instr;
  logic [4:0]  in_rd;

  logic        d_ready [N];
  logic        d_valid [N];
  logic        d_busy  [N];
  logic [31:0] d_data  [N];
  logic [31:0] d_tag   [N];
  logic [31:0] d_instr [N];
  logic [4:0]  d_rd    [N];
  int          d_infl  [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int S = st_of(gi);
    logic [$clog2(S+1)-1:0] infl;
    mul_pipe #(.XLEN(32), .STAGES(S)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(d_ready[gi]), .in_op(in_op),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd_addr(in_rd),
      .in_tag(in_tag), .in_instr(in_instr),
      .freeze(freeze), .flush(flush),
      .out_valid(d_valid[gi]), .out_ready(out_ready), .out_data(d_data[gi]),
      .out_rd_addr(d_rd[gi]), .out_tag(d_tag[gi]), .out_instr(d_instr[gi]),
      .busy(d_busy[gi]), .inflight(infl)
    );
    assign d_infl[gi] = int'(infl);
  end

  // Model: slot s of instance i holds the op that entered s-1 advances ago.
  bit          mv  [N][7];
  logic [31:0] md  [N][7];
  logic [31:0] mtg [N][7];
  logic [31:0] mis [N][7];
  logic [4:0]  mrd [N][7];
  int          delivered [N];
  int          base [N];
  logic [31:0] hold_d [N];
  int          n_chk = 0;
  int          n_pass = 0;

  function automatic logic [31:0] ref_mul(input logic [1:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == 2'd1 || op == 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (op == 2'd1)               ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string name, input int i, input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s dut%0d(STAGES=%0d): got %0h want %0h",
                  name, i, st_of(i), got, want);
  endtask

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      int S, cnt;
      bit bsy, adv;
      S   = st_of(i);
      cnt = 0;
      bsy = 0;
      for (int s = 1; s <= S; s++) begin
        cnt += int'(mv[i][s]);
        if (s < S) bsy |= mv[i][s];
      end
      adv = !freeze && (!mv[i][S] || out_ready);
      chk("out_valid", i, d_valid[i], mv[i][S]);
      if (mv[i][S]) begin
        chk("out_data", i, d_data[i], md[i][S]);
        chk("out_rd_addr", i, d_rd[i], mrd[i][S]);
        chk("out_tag", i, d_tag[i], mtg[i][S]);
        chk("out_instr", i, d_instr[i], mis[i][S]);
      end
      chk("in_ready", i, d_ready[i], adv);
      chk("inflight", i, d_infl[i], cnt);
      chk("busy", i, d_busy[i], bsy);
      if (rst) begin
        for (int s = 1; s <= S; s++) mv[i][s] = 0;
      end else begin
        if (adv && mv[i][S]) delivered[i]++;
        if (flush) begin
          for (int s = 1; s <= S; s++) mv[i][s] = 0;
        end else if (adv) begin
          for (int s = S; s >= 2; s--) begin
            mv[i][s] = mv[i][s-1];  md[i][s]  = md[i][s-1];
            mrd[i][s] = mrd[i][s-1]; mtg[i][s] = mtg[i][s-1];
            mis[i][s] = mis[i][s-1];
          end
          mv[i][1]  = in_valid;
          md[i][1]  = ref_mul(in_op, in_rs1, in_rs2);
          mrd[i][1] = in_rd;
          mtg[i][1] = in_tag;
          mis[i][1] = in_instr;
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_op();
    in_op    = 2'($urandom_range(0, 3));
    in_rs1   = rand_val();
    in_rs2   = rand_val();
    in_rd    = 5'($urandom_range(0, 31));
    in_tag   = $urandom;
    in_instr = $urandom;
  endtask

  task automatic check_reset_outputs(input string tagname);
    for (int i = 0; i < N; i++) begin
      chk({tagname, "_out_valid"}, i, d_valid[i], 0);
      chk({tagname, "_out_data"}, i, d_data[i], 0);
      chk({tagname, "_out_rd_addr"}, i, d_rd[i], 0);
      chk({tagname, "_out_tag"}, i, d_tag[i], 0);
      chk({tagname, "_out_instr"}, i, d_instr[i], 0);
      chk({tagname, "_busy"}, i, d_busy[i], 0);
      chk({tagname, "_inflight"}, i, d_infl[i], 0);
      chk({tagname, "_in_ready"}, i, d_ready[i], 1);
    end
  endtask

  // One op through an otherwise empty pipe, timed on the STAGES=3 instance.
  task automatic run_one(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] want);
    logic [4:0]  rd;
    logic [31:0] tg, ins;
    int n;
    rand_op();
    in_op = op; in_rs1 = a; in_rs2 = b; in_valid = 1'b1;
    rd = in_rd; tg = in_tag; ins = in_instr;
    cycle();
    in_valid = 1'b0;
    n = 1;
    while (!d_valid[1] && n < 12) begin
      cycle();
      n++;
    end
    chk("latency", 1, n, 3);
    chk("lit_data", 1, d_data[1], want);
    chk("lit_rd_addr", 1, d_rd[1], rd);
    chk("lit_tag", 1, d_tag[1], tg);
    chk("lit_instr", 1, d_instr[1], ins);
    repeat (8) cycle();
  endtask

  logic [1:0]  vec_op [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [31:0] vec_a  [5] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] vec_b  [5] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] vec_r  [5] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};

  initial begin
    rst = 1'b1; in_valid = 1'b0; freeze = 1'b0; flush = 1'b0; out_ready = 1'b1;
    rand_op();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      delivered[i] = 0;
      for (int s = 0; s < 7; s++) mv[i][s] = 0;
    end
    check_reset_outputs("reset");

    for (int k = 0; k < 5; k++) begin
      chk("model_literal", 1, ref_mul(vec_op[k], vec_a[k], vec_b[k]), vec_r[k]);
      run_one(vec_op[k], vec_a[k], vec_b[k], vec_r[k]);
    end

    // 20 back-to-back ops
    for (int i = 0; i < N; i++) base[i] = delivered[i];
    for (int k = 0; k < 20; k++) begin
      rand_op();
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    repeat (8) cycle();
    for (int i = 0; i < N; i++) chk("b2b_count", i, delivered[i] - base[i], 20);

    // Backpressure with a full pipe
    for (int i = 0; i < N; i++) base[i] = delivered[i];
    for (int k = 0; k < 6; k++) begin
      rand_op();
      in_valid = 1'b1;
      cycle();
    end
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) hold_d[i] = d_data[i];
    for (int k = 0; k < 4; k++) begin
      rand_op();
      cycle();
      for (int i = 0; i < N; i++) begin
        chk("hold_valid", i, d_valid[i], 1);
        chk("hold_data", i, d_data[i], hold_d[i]);
        chk("hold_in_ready", i, d_ready[i], 0);
      end
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (8) cycle();
    for (int i = 0; i < N; i++) chk("bp_count", i, delivered[i] - base[i], 6);

    // Random stream with freeze pulses and backpressure
    for (int k = 0; k < 80; k++) begin
      rand_op();
      in_valid  = 1'($urandom_range(0, 1));
      freeze    = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    freeze = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    repeat (8) cycle();

    // Flush with three ops in flight plus one presented
    for (int k = 0; k < 3; k++) begin
      rand_op();
      in_valid = 1'b1;
      cycle();
    end
    for (int i = 0; i < N; i++) base[i] = delivered[i];
    rand_op();
    flush = 1'b1; out_ready = 1'b0;
    cycle();
    flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("flush_out_valid", i, d_valid[i], 0);
      chk("flush_inflight", i, d_infl[i], 0);
      chk("flush_busy", i, d_busy[i], 0);
    end
    repeat (8) cycle();
    for (int i = 0; i < N; i++) chk("flush_no_output", i, delivered[i] - base[i], 0);

    // Reset with the pipe full, then one op afterwards
    for (int k = 0; k < 6; k++) begin
      rand_op();
      in_valid = 1'b1;
      cycle();
    end
    rst = 1'b1;
    rand_op();
    cycle();
    rst = 1'b0; in_valid = 1'b0;
    check_reset_outputs("midreset");
    run_one(2'd3, 32'h1234_5678, 32'h9ABC_DEF0, ref_mul(2'd3, 32'h1234_5678, 32'h9ABC_DEF0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mul_pipe.md
# mul_pipe

Parametrised, fully pipelined RV32M/RV64M integer multiplier for the EXU. It replaces the fixed three-stage multiplier with a configurable pipeline depth and native MUL/MULH/MULHSU/MULHU decode. It adds a valid/ready output handshake, whole-pipe freeze, and a pipeline flush. It sits beside the ALU in the execute stage, fed from IDU1 and drained by the writeback arbiter.

## Interface
- XLEN, 32, operand/result width (32 or 64)
- STAGES, 3, accept-to-result latency in cycles; legal range 2..6
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  request present
- in_ready  out  1  request accepted this cycle when in_valid & in_ready
- in_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- in_rs1, in_rs2  in  XLEN  operands
- in_rd_addr  in  5  destination register
- in_tag  in  XLEN  instruction tag, carried unchanged
- in_instr  in  32  instruction word, carried unchanged
- freeze  in  1  global stall; holds every stage
- flush  in  1  kills all in-flight ops and any op presented this cycle
- out_valid  out  1  result present
- out_ready  in  1  writeback accepts result
- out_data  out  XLEN  selected product half
- out_rd_addr, out_tag, out_instr  out  5/XLEN/32  sideband of the result op
- busy  out  1  any valid op in stages 1..STAGES-1
- inflight  out  $clog2(STAGES+1)  count of valid ops in stages 1..STAGES

## Operation
- Each stage s=1..STAGES holds a valid bit and its payload: rd_addr, tag, instr, low flag.
- Sign decode at input: rs1 is signed for MULH and MULHSU; rs2 is signed for MULH only. low = (op==MUL).
- Stage 1 registers {rs1_neg, rs1} and {rs2_neg, rs2} as (XLEN+1)-bit signed values. neg = signed & msb.
- The signed (XLEN+1)x(XLEN+1) multiply is combinational between stage 1 and stage 2. Bits [2*XLEN-1:0] are kept.
- Stages 2..STAGES carry the product unchanged, as retiming registers.
- out_data = low ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]. Outputs are driven from stage STAGES.
- advance = ~freeze & (~out_valid | out_ready). in_ready = advance.
- When advance is high, every stage shifts by one. Stage 1 loads in_valid & ~flush.
- When advance is low, all stages hold, valid bits included. The pipe is global-stall: no bubble collapsing.
- Flush takes priority over freeze and over backpressure. On the next edge all valid bits clear and payloads are don't-care. An op at the output with out_ready=1 in the flush cycle still counts as delivered.
- Payload registers load only when advance=1, so they do not toggle when idle.

## Timing
- Reset: all valid bits 0, all payload and product registers 0. Outputs therefore read out_valid=0, out_data=0, out_rd_addr=0, out_tag=0, out_instr=0, busy=0, inflight=0. in_ready follows freeze after reset (1 when freeze=0).
- Latency: if an op is accepted at edge k with no stalls, out_valid=1 during cycle k+STAGES.
- Throughput: one op per cycle sustained while out_ready=1 and freeze=0.
- Backpressure: out_valid=1 & out_ready=0 holds out_data and the sideband stable and drops in_ready the same cycle (combinational path out_ready to in_ready).
- Freeze and out_ready=0 together: hold. Freeze with out_ready=1: the result is not consumed, because advance=0 and the writeback side must also honour freeze.
- Reset mid-operation: in-flight ops are discarded with no output. out_valid is 0 on the first cycle after the reset edge.
- inflight changes by at most ±1 per cycle, except flush, which takes it to 0 in one cycle.

## Test plan
- MUL 7 x 0xFFFFFFFD (STAGES=3) -> out_data 0xFFFFFFEB, out_valid exactly 3 cycles after accept, rd_addr/tag/instr echoed.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MUL 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001.
- 20 back-to-back random ops with out_ready=1 -> 20 results on 20 consecutive cycles, in order, matching a reference model; repeat at STAGES=2 and STAGES=6.
- Hold out_ready=0 for 4 cycles with the pipe full -> in_ready=0 and output stable for all 4 cycles, no loss or duplication after release. Repeat with freeze pulses mid-stream.
- Flush with 3 ops in flight plus in_valid=1 -> next cycle inflight=0, busy=0, out_valid=0, and none of the 4 ops ever appears on the output.
- Assert rst with the pipe full -> next cycle all outputs at reset values. An op accepted afterwards completes with correct latency.
